// File: rtl/soc_system_neuron_pkg.sv
// Shared types and constants for the Q16.16 dot-product neuron sequencer.
// Optional feature macro: SOC_SYSTEM_NEURON_RELU_EN (clamps negative results to zero).
package soc_system_neuron_pkg;

   localparam int FRAC_BITS_DEF = 16;
   localparam int ACC_W_DEF     = 72;
   localparam int RAM_DEPTH     = 64;
   localparam int ADDR_W        = 6;
   localparam int LEN_W         = 7;

   localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] SAT_MIN = 32'h8000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_t;

   // Weight-RAM address base+offset, wrapping around the RAM depth.
   function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [LEN_W-1:0]  off);
      logic [LEN_W-1:0] sum_s;
      sum_s = {1'b0, base} + off;
      return sum_s[ADDR_W-1:0];
   endfunction

   // Term count limited to the RAM depth.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
      logic [LEN_W-1:0] res_s;
      if (len > LEN_W'(RAM_DEPTH)) begin
         res_s = LEN_W'(RAM_DEPTH);
      end else begin
         res_s = len;
      end
      return res_s;
   endfunction

endpackage

// File: rtl/soc_system_neuron_sat.sv
// Combinational result stage: arithmetic shift by FRAC_BITS, 32-bit signed
// saturation and, when SOC_SYSTEM_NEURON_RELU_EN is defined, a ReLU clamp.
module soc_system_neuron_sat
   import soc_system_neuron_pkg::*;
#(
   parameter int FRAC_BITS = FRAC_BITS_DEF,
   parameter int ACC_W     = ACC_W_DEF
) (
   input  logic signed [ACC_W-1:0] acc,
   output logic        [31:0]      result
);

   logic signed [ACC_W-1:0] shifted_s;
   logic        [ACC_W-32:0] upper_s;
   logic        [31:0]      sat_s;

   // Shift out the fraction and clamp anything outside the signed 32-bit range.
   always_comb begin
      shifted_s = acc >>> FRAC_BITS;
      upper_s   = shifted_s[ACC_W-1:31];
      if ((&upper_s) || (~|upper_s)) begin
         sat_s = shifted_s[31:0];
      end else if (shifted_s[ACC_W-1]) begin
         sat_s = SAT_MIN;
      end else begin
         sat_s = SAT_MAX;
      end
   end

`ifdef SOC_SYSTEM_NEURON_RELU_EN
   // Negative saturated results are forced to zero.
   always_comb begin
      if (sat_s[31]) begin
         result = 32'h0000_0000;
      end else begin
         result = sat_s;
      end
   end
`else
   // Signed saturated result passes through untouched.
   always_comb begin
      result = sat_s;
   end
`endif

endmodule

// File: rtl/soc_system_neuron_seq.sv
// Dot-product sequencer: streams len weights from a synchronous weight RAM,
// multiplies each with a handshaked Q16.16 operand, accumulates and returns
// a saturated Q16.16 result. Optional macro: SOC_SYSTEM_NEURON_RELU_EN.
module soc_system_neuron_seq
   import soc_system_neuron_pkg::*;
#(
   parameter int FRAC_BITS = FRAC_BITS_DEF,
   parameter int ACC_W     = ACC_W_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [5:0]  base_i,
   input  logic [6:0]  len_i,
   input  logic        abort,
   output logic        busy,
   output logic [5:0]  w_address,
   output logic        w_chipselect,
   output logic        w_write,
   output logic [3:0]  w_byteenable,
   output logic        w_clken,
   input  logic [31:0] w_readdata,
   input  logic        x_valid,
   output logic        x_ready,
   input  logic [31:0] x_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);

   state_t                  state_r, state_nxt_s;
   logic [LEN_W-1:0]        len_r, cnt_r, cnt_inc_s, len_clamp_s;
   logic [ADDR_W-1:0]       base_r, addr_r;
   logic signed [ACC_W-1:0] acc_r, acc_nxt_s;
   logic signed [63:0]      prod_s;
   logic [31:0]             out_data_r, sat_res_s;
   logic                    hs_s, last_s;

   assign w_write      = 1'b0;
   assign w_byteenable = 4'hF;
   assign w_clken      = 1'b1;
   assign out_data     = out_data_r;

   // Product, next accumulator and handshake qualifiers.
   always_comb begin
      len_clamp_s = clamp_len(len_i);
      cnt_inc_s   = cnt_r + 7'd1;
      hs_s        = (state_r == ST_MAC) && x_valid;
      last_s      = hs_s && (cnt_inc_s == len_r);
      prod_s      = $signed({{32{w_readdata[31]}}, w_readdata}) *
                    $signed({{32{x_data[31]}}, x_data});
      acc_nxt_s   = acc_r + {{(ACC_W-64){prod_s[63]}}, prod_s};
   end

   soc_system_neuron_sat #(
      .FRAC_BITS (FRAC_BITS),
      .ACC_W     (ACC_W)
   ) u_sat (
      .acc    (acc_nxt_s),
      .result (sat_res_s)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort wins over any handshake.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_nxt_s = (len_clamp_s == 7'd0) ? ST_OUT : ST_MAC;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MAC: begin
            if (abort) begin
               state_nxt_s = ST_IDLE;
            end else if (last_s) begin
               state_nxt_s = ST_OUT;
            end else begin
               state_nxt_s = ST_MAC;
            end
         end
         ST_OUT: begin
            if (abort || out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_OUT;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Output decode; the RAM address runs one term ahead on each handshake.
   always_comb begin
      busy         = (state_r != ST_IDLE);
      x_ready      = 1'b0;
      w_chipselect = 1'b0;
      out_valid    = 1'b0;
      w_address    = addr_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               w_address = base_i;
            end else begin
               w_address = addr_r;
            end
         end
         ST_MAC: begin
            x_ready      = 1'b1;
            w_chipselect = 1'b1;
            if (hs_s) begin
               w_address = wrap_addr(base_r, cnt_inc_s);
            end else begin
               w_address = wrap_addr(base_r, cnt_r);
            end
         end
         ST_OUT: begin
            out_valid = 1'b1;
         end
         default: begin
            w_address = addr_r;
         end
      endcase
   end

   // Datapath: operation setup, accumulation and result capture.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         len_r      <= 7'd0;
         base_r     <= 6'd0;
         cnt_r      <= 7'd0;
         acc_r      <= '0;
         addr_r     <= 6'd0;
         out_data_r <= 32'h0000_0000;
      end else begin
         addr_r <= w_address;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  len_r  <= len_clamp_s;
                  base_r <= base_i;
                  cnt_r  <= 7'd0;
                  acc_r  <= '0;
                  if (len_clamp_s == 7'd0) begin
                     out_data_r <= 32'h0000_0000;
                  end
               end
            end
            ST_MAC: begin
               if (hs_s && !abort) begin
                  acc_r <= acc_nxt_s;
                  cnt_r <= cnt_inc_s;
                  if (last_s) begin
                     out_data_r <= sat_res_s;
                  end
               end
            end
            default: begin
               out_data_r <= out_data_r;
            end
         endcase
      end
   end

endmodule

// File: doc/soc_system_neuron_seq.md
SOC_SYSTEM_NEURON_SEQ -- requirements
Module: soc_system_neuron_seq

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16: fixed-point fraction bits of Q16.16 operands and result.
REQ-002 SHALL have parameter ACC_W, default 72: accumulator width in bits.
REQ-003 clk  in  1  sole clock; all state is updated on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request a dot product; sampled only in IDLE.
REQ-006 base_i  in  6  first weight-RAM word address.
REQ-007 len_i  in  7  number of terms; 0 is allowed, values >64 clamp to 64.
REQ-008 abort  in  1  synchronous cancel of the current operation.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 w_address  out  6  weight-RAM port address.
REQ-011 w_chipselect  out  1  weight-RAM select.
REQ-012 w_write  out  1  tied 0.
REQ-013 w_byteenable  out  4  tied 4'hF.
REQ-014 w_clken  out  1  tied 1.
REQ-015 w_readdata  in  32  signed weight; valid one cycle after the address is presented (address registered in RAM, output unregistered).
REQ-016 x_valid / x_ready  in / out  1 / 1  input-operand handshake.
REQ-017 x_data  in  32  signed Q16.16 input operand.
REQ-018 out_valid / out_ready  out / in  1 / 1  result handshake.
REQ-019 out_data  out  32  signed Q16.16 result.

Function
REQ-020 SHALL implement the states IDLE, MAC and OUT.
REQ-021 IDLE: when start=1, latch min(len_i,64) and base_i, clear acc and cnt, drive w_address=base_i combinationally, and go to MAC (or to OUT if len=0).
REQ-022 MAC: x_ready=1 and w_chipselect=1; on handshake, acc += sign-extended w_readdata*x_data (64-bit product) and cnt++.
REQ-023 MAC: w_address SHALL be (base+cnt+1) mod 64 combinationally in the handshake cycle, otherwise (base+cnt) mod 64; this gives a throughput of one term per cycle.
REQ-024 Address arithmetic SHALL wrap mod 64, e.g. base 62 with len 4 reads 62,63,0,1.
REQ-025 The handshake that completes term len SHALL move the FSM to OUT on the next edge, with out_valid=1 one cycle after the last handshake.
REQ-026 OUT: out_data = sat32(acc >>> FRAC_BITS), arithmetic shift; sat32 clamps to 0x7FFFFFFF / 0x80000000; out_data SHALL be held stable while out_valid=1.
REQ-027 OUT: out_valid && out_ready SHALL return the FSM to IDLE; start SHALL be ignored while busy.
REQ-028 len=0 SHALL produce out_data=0.
REQ-029 abort=1 in MAC or OUT SHALL go to IDLE on the next edge; no result is produced, and abort takes priority over a simultaneous handshake.
REQ-030 Outside MAC, x_ready=0, w_chipselect=0, and w_address SHALL hold its last value.

Reset
REQ-031 Reset SHALL immediately force IDLE and set busy=0, x_ready=0, out_valid=0, out_data=0, w_chipselect=0, w_address=0, acc=0, cnt=0.
REQ-032 Reset mid-operation SHALL discard the partial sum; the first start after release SHALL behave normally.

Configuration
REQ-033 When macro SOC_SYSTEM_NEURON_RELU_EN is defined, out_data SHALL be max(0, sat32 result).
REQ-034 When the macro is undefined, the signed saturated result SHALL pass unchanged; the macro SHALL not change timing or ports.

Structure
REQ-035 Package soc_system_neuron_pkg SHALL hold the state enum, the ACC_W/FRAC_BITS defaults, the SAT_MAX/SAT_MIN constants and the RAM depth constant (64).
REQ-036 Sub-module soc_system_neuron_sat SHALL be combinational and implement shift, saturate and optional ReLU.

Verification
REQ-037 base=0, len=3, weights {0x00010000,0x00020000,0xFFFF0000}, x=0x00010000 held valid, start at t0 -> out_valid at t4 with out_data=0x00020000.
REQ-038 base=62, len=4 -> w_address sequence 62,63,0,1; result equals the reference dot product.
REQ-039 len=64 with every weight and x = 0x7FFFFFFF -> out_data=0x7FFFFFFF; with weights 0x80000000 and x 0x7FFFFFFF -> 0x80000000, or 0 when RELU_EN is defined.
REQ-040 Result -2.0 -> out_data=0xFFFE0000 without the macro and 0x00000000 with it; out_ready low for 5 cycles -> out_data held, busy=1, start ignored.
REQ-041 Reset asserted mid-MAC -> all outputs 0 immediately; len=0 start -> out_valid next cycle with 0; abort with a simultaneous handshake -> IDLE and no out_valid.
